// File: rtl/if_stage_pkg.sv
// Constants and types shared across the fetch stage and its neighbours.
package if_stage_pkg;

    localparam logic [31:0] NOP_WORD         = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] WORD_ALIGN_MASK  = 32'hFFFF_FFFC;

    // Also consumed by the hazard unit for debug visibility.
    typedef enum logic [1:0] {
        PC_SEQ    = 2'd0,
        PC_JUMP   = 2'd1,
        PC_BRANCH = 2'd2,
        PC_HOLD   = 2'd3
    } pc_sel_e;

endpackage

// File: rtl/if_stage_pc_next_sel.sv
// Priority select for the next PC: EX branch, then ID jump, then stall hold, else sequential.
module pc_next_sel
    import if_stage_pkg::*;
(
    input  logic        i_stall,
    input  logic        i_id_jump,
    input  logic [31:0] i_id_jump_target,
    input  logic        i_ex_branch_taken,
    input  logic [31:0] i_ex_branch_target,
    input  logic [31:0] i_pc,
    output pc_sel_e     o_sel,
    output logic [31:0] o_next_pc,
    output logic [31:0] o_pc_plus4
);

    assign o_pc_plus4 = i_pc + 32'd4;

    // The branch is older than the stalled instruction, so it beats the stall.
    always_comb begin
        o_sel     = PC_SEQ;
        o_next_pc = o_pc_plus4;
        if (i_ex_branch_taken) begin
            o_sel     = PC_BRANCH;
            o_next_pc = i_ex_branch_target & WORD_ALIGN_MASK;
        end else if (i_id_jump && !i_stall) begin
            o_sel     = PC_JUMP;
            o_next_pc = i_id_jump_target & WORD_ALIGN_MASK;
        end else if (i_stall) begin
            o_sel     = PC_HOLD;
            o_next_pc = i_pc;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: program counter, next-PC selection and the IF/ID register.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter logic [31:0] NOP_INSTR = NOP_WORD
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        id_jump,
    input  logic [31:0] id_jump_target,
    input  logic        ex_branch_taken,
    input  logic [31:0] ex_branch_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc_plus4,
    output logic        ifid_valid
);

    logic [31:0] r_pc;
    logic [31:0] r_ifid_instr;
    logic [31:0] r_ifid_pc_plus4;
    logic        r_ifid_valid;

    pc_sel_e     w_sel;
    logic [31:0] w_next_pc;
    logic [31:0] w_pc_plus4;

    pc_next_sel u_pc_next_sel (
        .i_stall            (stall),
        .i_id_jump          (id_jump),
        .i_id_jump_target   (id_jump_target),
        .i_ex_branch_taken  (ex_branch_taken),
        .i_ex_branch_target (ex_branch_target),
        .i_pc               (r_pc),
        .o_sel              (w_sel),
        .o_next_pc          (w_next_pc),
        .o_pc_plus4         (w_pc_plus4)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc            <= RESET_PC;
            r_ifid_instr    <= NOP_INSTR;
            r_ifid_pc_plus4 <= '0;
            r_ifid_valid    <= 1'b0;
        end else begin
            case (w_sel)
                PC_BRANCH, PC_JUMP: begin
                    r_pc            <= w_next_pc;
                    r_ifid_instr    <= NOP_INSTR;
                    r_ifid_pc_plus4 <= '0;
                    r_ifid_valid    <= 1'b0;
                end
                PC_SEQ: begin
                    r_pc            <= w_next_pc;
                    r_ifid_instr    <= imem_instr;
                    r_ifid_pc_plus4 <= w_pc_plus4;
                    r_ifid_valid    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign imem_addr     = r_pc;
    assign ifid_instr    = r_ifid_instr;
    assign ifid_pc_plus4 = r_ifid_pc_plus4;
    assign ifid_valid    = r_ifid_valid;

endmodule

// File: tb/tb_if_stage.sv
// Randomized and directed bench for if_stage against a behavioural fetch-stage model.
module tb_if_stage;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        id_jump;
    logic [31:0] id_jump_target;
    logic        ex_branch_taken;
    logic [31:0] ex_branch_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc_plus4;
    logic        ifid_valid;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Model state
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_pc4;
    logic        m_valid;

    if_stage #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (32'h0000_0000)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .stall            (stall),
        .id_jump          (id_jump),
        .id_jump_target   (id_jump_target),
        .ex_branch_taken  (ex_branch_taken),
        .ex_branch_target (ex_branch_target),
        .imem_addr        (imem_addr),
        .imem_instr       (imem_instr),
        .ifid_instr       (ifid_instr),
        .ifid_pc_plus4    (ifid_pc_plus4),
        .ifid_valid       (ifid_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0)      return 32'h2004_0001;
        else if (a == 32'h4) return 32'h2005_0002;
        else if (a == 32'h8) return 32'h0085_3020;
        else                 return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    always_comb imem_instr = mem_word(imem_addr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".addr"},  imem_addr, m_pc);
        check({tag, ".instr"}, ifid_instr, m_instr);
        check({tag, ".pc4"},   ifid_pc_plus4, m_pc4);
        check({tag, ".valid"}, {31'b0, ifid_valid}, {31'b0, m_valid});
    endtask

    task automatic model_reset();
        m_pc    = 32'h0;
        m_instr = 32'h0;
        m_pc4   = 32'h0;
        m_valid = 1'b0;
    endtask

    // One clock: apply inputs, update the model by the fetch rules, compare after the edge.
    task automatic step(input logic br, input logic [31:0] bt, input logic j,
                        input logic [31:0] jt, input logic st, input string tag);
        ex_branch_taken  = br;
        ex_branch_target = bt;
        id_jump          = j;
        id_jump_target   = jt;
        stall            = st;
        @(posedge clk);
        if (br) begin
            m_pc = {bt[31:2], 2'b00};
            m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
        end else if (j && !st) begin
            m_pc = {jt[31:2], 2'b00};
            m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
        end else if (!st) begin
            m_instr = mem_word(m_pc);
            m_pc    = m_pc + 32'd4;
            m_pc4   = m_pc;
            m_valid = 1'b1;
        end
        #1;
        check_all(tag);
    endtask

    task automatic async_reset(input string tag);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all({tag, ".now"});
        @(posedge clk);
        #1;
        check_all({tag, ".held"});
        #2 rst_n = 1'b1;
    endtask

    initial begin
        stall = 0; id_jump = 0; ex_branch_taken = 0;
        id_jump_target = '0; ex_branch_target = '0;
        rst_n = 1'b1;
        model_reset();
        #2 rst_n = 1'b0;
        #1 check_all("reset");
        @(posedge clk);
        #1 check_all("reset_edge");
        #2 rst_n = 1'b1;

        // Sequential fetch from reset
        step(0, 0, 0, 0, 0, "seq0");
        check("seq0.k_instr", ifid_instr, 32'h2004_0001);
        step(0, 0, 0, 0, 0, "seq1");
        check("seq1.k_addr", imem_addr, 32'h8);
        // Stall two cycles at pc=8
        step(0, 0, 0, 0, 1, "stall0");
        step(0, 0, 0, 0, 1, "stall1");
        check("stall1.k_instr", ifid_instr, 32'h2005_0002);
        check("stall1.k_pc4", ifid_pc_plus4, 32'h8);
        step(0, 0, 0, 0, 0, "release");
        check("release.k_instr", ifid_instr, 32'h0085_3020);
        // Jump to 0x40
        step(0, 0, 1, 32'h40, 0, "jump");
        check("jump.k_valid", {31'b0, ifid_valid}, 32'h0);
        step(0, 0, 0, 0, 0, "jump_fetch");
        check("jump_fetch.k_pc4", ifid_pc_plus4, 32'h44);
        // Branch beats stall and jump; target bits [1:0] dropped
        step(1, 32'h103, 1, 32'h80, 1, "br_all");
        check("br_all.k_addr", imem_addr, 32'h100);
        step(0, 0, 1, 32'h80, 1, "jump_stall");
        check("jump_stall.k_addr", imem_addr, 32'h100);
        // Wrap at top of address space
        step(1, 32'hFFFF_FFFF, 0, 0, 0, "wrap_br");
        step(0, 0, 0, 0, 0, "wrap");
        check("wrap.k_pc4", ifid_pc_plus4, 32'h0);
        // Async reset mid-run at pc=0x44
        step(0, 0, 1, 32'h40, 0, "pre_rst_j");
        step(0, 0, 0, 0, 0, "pre_rst");
        async_reset("midrst");
        step(0, 0, 0, 0, 0, "post_rst");

        for (int i = 0; i < 400; i++) begin
            logic        br, j, st;
            logic [31:0] bt, jt;
            br = ($urandom_range(0, 99) < 12);
            j  = ($urandom_range(0, 99) < 20);
            st = ($urandom_range(0, 99) < 30);
            bt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15)) : $urandom;
            jt = $urandom;
            step(br, bt, j, jt, st, "rand");
            if ($urandom_range(0, 99) < 2) async_reset("rand_rst");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage pipeline.
- Owns the program counter and drives the combinational instruction memory address.
- Selects the next PC from the sequential path, an ID-stage jump or an EX-stage branch.
- Holds the IF/ID pipeline register that feeds decode; honours hazard-unit stalls and inserts bubbles on control redirects.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, instruction word written into IF/ID on a flush (sll $0,$0,0).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  hazard-unit hold request (load-use); freezes PC and IF/ID.
- id_jump  in  1  jump (j/jal/jr) resolved in ID this cycle.
- id_jump_target  in  32  jump destination.
- ex_branch_taken  in  1  branch resolved taken in EX this cycle.
- ex_branch_target  in  32  branch destination.
- imem_addr  out  32  address to instruction memory; equals the PC register.
- imem_instr  in  32  instruction word returned combinationally for imem_addr.
- ifid_instr  out  32  registered instruction to decode.
- ifid_pc_plus4  out  32  registered PC+4 of that instruction (link and branch base).
- ifid_valid  out  1  1 = ifid_instr is a real fetched instruction; 0 = bubble.

Behaviour:
- Reset (rst_n=0, asynchronous, effective immediately):
  - pc = RESET_PC, so imem_addr = RESET_PC.
  - ifid_instr = NOP_INSTR, ifid_pc_plus4 = 0, ifid_valid = 0.
- Deassertion of reset:
  - First rising edge after rst_n rises captures the instruction at RESET_PC into IF/ID and advances pc to RESET_PC+4.
- Latency: instruction at address A appears on ifid_instr one clock after imem_addr = A.
- Memory interface:
  - imem_addr is purely the PC register; no combinational path from any input to imem_addr.
  - Memory read is zero-wait; no handshake.
- Next-PC / IF/ID update, evaluated each rising edge, first match wins:
  1. ex_branch_taken=1: pc <= {ex_branch_target[31:2],2'b00}; IF/ID <= bubble (NOP_INSTR, valid=0, pc_plus4=0). Honoured even when stall=1, because the branch is older than the stalled instruction.
  2. id_jump=1 and stall=0: pc <= {id_jump_target[31:2],2'b00}; IF/ID <= bubble.
  3. stall=1: pc and IF/ID hold their values. An id_jump arriving together with stall is ignored; decode re-presents it after the stall releases.
  4. Otherwise: pc <= pc+4; ifid_instr <= imem_instr; ifid_pc_plus4 <= pc+4; ifid_valid <= 1.
- Arithmetic:
  - pc+4 is 32-bit, wrapping modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
  - Target bits [1:0] are forced to zero; no misalignment exception.
- Simultaneous events:
  - ex_branch_taken together with id_jump: branch wins and the jump is discarded (it lies on the squashed path).
- Reset mid-operation: asynchronous reset overrides all pending redirects and stalls in the same instant.
- Bubble content: ifid_instr = NOP_INSTR guarantees decode produces no register write even if ifid_valid is ignored downstream.

Decomposition:
- Shared pipeline package:
  - NOP_INSTR constant.
  - RESET_PC default.
  - Next-PC select encoding (PC_SEQ=2'd0, PC_JUMP=2'd1, PC_BRANCH=2'd2, PC_HOLD=2'd3), also used by the hazard unit for debug visibility.
- Sub-module: pc_next_sel (combinational priority mux producing the select code and next pc).
- PC and IF/ID registers stay in if_stage.

Test Plan:
- Reset/sequential: memory holds 0x20040001, 0x20050002, 0x00853020 at 0/4/8.
  - Release rst_n: imem_addr goes 0,4,8,C on successive edges.
  - ifid_instr shows 0x20040001, 0x20050002, 0x00853020 one edge later.
  - ifid_pc_plus4 shows 4, 8, C; ifid_valid=1 from the first edge.
- Stall: assert stall for 2 cycles while pc=8.
  - pc stays 8; ifid_instr stays 0x20050002 and ifid_pc_plus4 stays 8 for both cycles.
  - Next edge after release: 0x00853020, ifid_pc_plus4=C.
- Jump: id_jump=1, target=0x40 at pc=C.
  - Next edge: pc=0x40, ifid_valid=0, ifid_instr=0.
  - Following edge: captures the word at 0x40 with ifid_pc_plus4=0x44.
- Branch vs stall/jump: ex_branch_taken=1 (target 0x103), stall=1 and id_jump=1 (target 0x80) all in the same cycle.
  - pc=0x100 and IF/ID bubbled; jump and stall ignored.
  - With stall=1 and id_jump=1 only: pc holds.
- Wrap: force pc to 0xFFFFFFFC via branch target.
  - Next sequential edge: pc=0, ifid_pc_plus4=0.
- Async reset mid-run: drop rst_n between clock edges at pc=0x44.
  - imem_addr=RESET_PC and ifid_valid=0 immediately, without waiting for a clock edge.
